adf4350_loader: RTL and testbench

Serial programming engine for the ADF4350 synthesizers, driving the D_CLK / D_OUT / D_LE pins on the 80 MHz PLL output clock. It sits directly downstream of the command decoder in the ADC/FT245 datapath: the decoder writes 32-bit register images into six shadow registers, then pulses START. The block shifts the words out MSB-first in ADF4350 order and reports BUSY and DONE. One instance serves the RF synthesizer; a second instance serves the LO synthesizer.

---
 rtl/adf4350_loader.sv | 139 +++++++++++++
 tb/tb_adf4350_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adf4350_loader.sv
// ADF4350 serial programming engine: shifts six 32-bit shadow words (R5..R0, or R0 only)
// MSB-first on D_CLK/D_OUT and latches each with a D_LE pulse. All pins are registered.
module adf4350_loader #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned LE_WIDTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WR_EN,
  input  logic [2:0]  WR_ADDR,
  input  logic [31:0] WR_DATA,
  input  logic        START,
  input  logic        QUICK,
  output logic        BUSY,
  output logic        DONE,
  output logic        D_CLK,
  output logic        D_OUT,
  output logic        D_LE
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT_LO, SHIFT_HI, LE_SETUP, LE_HIGH, LE_GAP, FINISH
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] LE_LAST  = 8'(LE_WIDTH - 1);

  state_t           state_q, state_d;
  logic [5:0][31:0] shadow_q;
  logic [31:0]      sr_q, sr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             busy_q, done_q, dclk_q, dout_q, dle_q;
  logic [7:0]       cnt_last;
  logic             tick;
  logic [31:0]      load_word;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 6; i++) shadow_q[i] <= {29'd0, 3'(i)};
    end else if (WR_EN && (WR_ADDR < 3'd6)) begin
      shadow_q[WR_ADDR] <= {WR_DATA[31:3], WR_ADDR};
    end
  end

  // A write to the word being loaded this cycle wins over the stored shadow value.
  assign load_word = (WR_EN && (WR_ADDR == ptr_q)) ? {WR_DATA[31:3], ptr_q} : shadow_q[ptr_q];

  assign cnt_last = (state_q == LE_HIGH || state_q == LE_GAP) ? LE_LAST : DIV_LAST;
  assign tick     = (cnt_q == cnt_last);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          ptr_d   = QUICK ? 3'd0 : 3'd5;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sr_d    = load_word;
        bit_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT_LO;
      end
      SHIFT_LO, LE_SETUP, LE_HIGH: begin
        cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
        if (tick) begin
          case (state_q)
            SHIFT_LO: state_d = SHIFT_HI;
            LE_SETUP: state_d = LE_HIGH;
            default:  state_d = LE_GAP;
          endcase
        end
      end
      SHIFT_HI: begin
        cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
        if (tick) begin
          sr_d    = {sr_q[30:0], 1'b0};
          bit_d   = bit_q + 5'd1;
          state_d = (bit_q == 5'd31) ? LE_SETUP : SHIFT_LO;
        end
      end
      LE_GAP: begin
        cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
        if (tick) begin
          if (ptr_q == 3'd0) begin
            state_d = FINISH;
          end else begin
            ptr_d   = ptr_q - 3'd1;
            state_d = LOAD;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dclk_q  <= 1'b0;
      dout_q  <= 1'b0;
      dle_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ptr_q   <= ptr_d;
      busy_q  <= (state_d != IDLE) && (state_d != FINISH);
      done_q  <= (state_d == FINISH);
      dclk_q  <= (state_d == SHIFT_HI);
      dout_q  <= ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) && sr_d[31];
      dle_q   <= (state_d == LE_HIGH);
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign D_CLK = dclk_q;
  assign D_OUT = dout_q;
  assign D_LE  = dle_q;

endmodule

// File: tb/tb_adf4350_loader.sv
// Bench for adf4350_loader: a serial-pin monitor rebuilds latched words and timing,
// checked against a shadow-register model and the per-word cycle formula.
`timescale 1ns/1ps
module tb_adf4350_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WR_EN = 1'b0;
  logic [2:0]  WR_ADDR = 3'd0;
  logic [31:0] WR_DATA = 32'd0;
  logic        START = 1'b0;
  logic        QUICK = 1'b0;
  logic        busy0, done0, dclk0, dout0, dle0;
  logic        busy1, done1, dclk1, dout1, dle1;

  always #5 CLK = ~CLK;

  adf4350_loader dut0 (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .START(START), .QUICK(QUICK), .BUSY(busy0), .DONE(done0),
    .D_CLK(dclk0), .D_OUT(dout0), .D_LE(dle0)
  );

  adf4350_loader #(.CLK_DIV(1), .LE_WIDTH(1)) dut1 (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .START(START), .QUICK(QUICK), .BUSY(busy1), .DONE(done1),
    .D_CLK(dclk1), .D_OUT(dout1), .D_LE(dle1)
  );

  bit   sel = 1'b0;
  logic m_busy, m_done, m_dclk, m_dout, m_dle;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_dclk = sel ? dclk1 : dclk0;
  assign m_dout = sel ? dout1 : dout0;
  assign m_dle  = sel ? dle1  : dle0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;
  int done_base = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pin monitor: sampled on the falling edge, away from the DUT's active edge.
  logic        p_dclk = 1'b0, p_dle = 1'b0;
  logic [31:0] msr = '0;
  int          nbits = 0, hi_run = 0, le_run = 0, done_cnt = 0, done_rel = 0;
  logic [31:0] capq [$];
  int          nbq [$];
  int          leq [$];
  int          hiq [$];

  always @(negedge CLK) begin
    if (!RST) begin
      p_dclk <= 1'b0;
      p_dle  <= 1'b0;
      nbits  <= 0;
      hi_run <= 0;
      le_run <= 0;
    end else begin
      if (m_dclk) hi_run <= hi_run + 1;
      else if (p_dclk) begin
        hiq.push_back(hi_run);
        hi_run <= 0;
      end
      if (m_dclk && !p_dclk) begin
        msr   <= {msr[30:0], m_dout};
        nbits <= nbits + 1;
      end
      if (m_dle && !p_dle) begin
        capq.push_back(msr);
        nbq.push_back(nbits);
        nbits <= 0;
      end
      if (m_dle) le_run <= le_run + 1;
      else if (p_dle) begin
        leq.push_back(le_run);
        le_run <= 0;
      end
      if (m_done) begin
        done_cnt <= done_cnt + 1;
        done_rel <= cyc - c0 + 1;
      end
      p_dclk <= m_dclk;
      p_dle  <= m_dle;
    end
  end

  // Reference model: what the shadow registers hold, and what a word looks like on the wire.
  logic [31:0] msh [6];

  function automatic logic [31:0] img(input int idx);
    return {msh[idx][31:3], 3'(idx)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) msh[i] = 32'd0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    model_reset();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input bit upd);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    @(posedge CLK); #1;
    WR_EN = 1'b0;
    if (upd && a < 3'd6) msh[a] = d;
  endtask

  // Returns #1 after the edge that samples START, i.e. at the start of cycle 1.
  task automatic go(input bit q);
    capq.delete(); nbq.delete(); leq.delete(); hiq.delete();
    done_base = done_cnt;
    chk("busy_before_start", 32'(m_busy), 32'd0);
    START = 1'b1; QUICK = q;
    @(posedge CLK); #1;
    c0 = cyc;
    START = 1'b0; QUICK = 1'b0;
    chk("busy_cycle1", 32'(m_busy), 32'd1);
  endtask

  task automatic step_to(input int k);
    while ((cyc - c0 + 1) < k) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_done(input int limit);
    while ((done_cnt - done_base) == 0 && (cyc - c0 + 1) < limit) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic finish_check(input string tag, input bit q, input int exp_done,
                              input int exp_le, input int exp_div);
    int n, idx, badhi;
    repeat (30) @(posedge CLK);
    #1;
    n = q ? 1 : 6;
    chk($sformatf("%s done_cycle", tag), 32'(done_rel), 32'(exp_done));
    chk($sformatf("%s done_count", tag), 32'(done_cnt - done_base), 32'd1);
    chk($sformatf("%s busy_after", tag), 32'(m_busy), 32'd0);
    chk($sformatf("%s nwords", tag), 32'(capq.size()), 32'(n));
    for (int k = 0; k < n && k < capq.size(); k++) begin
      idx = q ? 0 : 5 - k;
      chk($sformatf("%s word%0d", tag, k), capq[k], img(idx));
      chk($sformatf("%s bits%0d", tag, k), 32'(nbq[k]), 32'd32);
      if (k < leq.size()) chk($sformatf("%s le_width%0d", tag, k), 32'(leq[k]), 32'(exp_le));
    end
    badhi = 0;
    foreach (hiq[i]) if (hiq[i] != exp_div) badhi++;
    chk($sformatf("%s dclk_pulses", tag), 32'(hiq.size()), 32'(32 * n));
    chk($sformatf("%s dclk_high_len", tag), 32'(badhi), 32'd0);
  endtask

  typedef struct {
    bit          sel;
    bit          quick;
    logic [31:0] w [6];
    int          exp_done;
    int          exp_le;
    int          exp_div;
  } vec_t;

  vec_t vt [6];
  logic [31:0] spec_w [6];

  initial begin
    int quiet;
    spec_w = '{32'h00400000, 32'h08008011, 32'h00004E42,
               32'h000004B3, 32'h00EC803C, 32'h00580005};
    model_reset();

    // Reset then idle.
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_pins", {27'd0, busy0, done0, dclk0, dout0, dle0}, 32'd0);
    RST = 1'b1;
    quiet = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if ({busy0, done0, dclk0, dout0, dle0, busy1, done1, dclk1, dout1, dle1} != 10'd0) quiet++;
    end
    chk("idle_quiet", 32'(quiet), 32'd0);

    // Table: spec vectors plus randomized rows.
    vt[0].sel = 0; vt[0].quick = 0; vt[0].w = spec_w; vt[0].exp_done = 1615;
    vt[0].exp_le = 4; vt[0].exp_div = 4;
    vt[1].sel = 0; vt[1].quick = 1; vt[1].w = spec_w; vt[1].w[0] = 32'h0064801F;
    vt[1].exp_done = 270; vt[1].exp_le = 4; vt[1].exp_div = 4;
    vt[2].sel = 1; vt[2].quick = 0; vt[2].w = spec_w; vt[2].exp_done = 409;
    vt[2].exp_le = 1; vt[2].exp_div = 1;
    for (int r = 3; r < 6; r++) begin
      vt[r].sel   = 1'($urandom_range(0, 1));
      vt[r].quick = 1'($urandom_range(0, 1));
      for (int i = 0; i < 6; i++) vt[r].w[i] = $urandom;
      vt[r].exp_div  = vt[r].sel ? 1 : 4;
      vt[r].exp_le   = vt[r].sel ? 1 : 4;
      vt[r].exp_done = 1 + (vt[r].quick ? 1 : 6) * (1 + 65 * vt[r].exp_div + 2 * vt[r].exp_le);
    end

    for (int r = 0; r < 6; r++) begin
      do_reset();
      sel = vt[r].sel;
      for (int i = 0; i < 6; i++) wr(3'(i), vt[r].w[i], 1'b1);
      wr(3'd6, $urandom, 1'b1);
      wr(3'd7, $urandom, 1'b1);
      @(posedge CLK); #1;
      go(vt[r].quick);
      wait_done(vt[r].exp_done + 50);
      finish_check($sformatf("vec%0d", r), vt[r].quick, vt[r].exp_done, vt[r].exp_le, vt[r].exp_div);
    end

    // START while busy is ignored; an early write to R0 reaches the last word.
    do_reset();
    sel = 1'b0;
    for (int i = 0; i < 6; i++) wr(3'(i), spec_w[i], 1'b1);
    go(1'b0);
    step_to(50);  START = 1'b1;
    step_to(51);  START = 1'b0;
    step_to(800); START = 1'b1;
    step_to(801); START = 1'b0;
    step_to(900);
    wr(3'd0, 32'h12345670, 1'b1);
    wait_done(1700);
    finish_check("start_ignored", 1'b0, 1615, 4, 4);
    chk("late_r0_word", capq.size() == 6 ? capq[5] : 32'd0, 32'h12345670);

    // Reset mid-sequence, then a clean run from reset shadow values.
    do_reset();
    for (int i = 0; i < 6; i++) wr(3'(i), spec_w[i], 1'b1);
    go(1'b0);
    step_to(600);
    chk("midseq_busy", 32'(busy0), 32'd1);
    chk("midseq_words", 32'(capq.size()), 32'd2);
    #2 RST = 1'b0;
    #1;
    chk("reset_async_pins", {28'd0, dclk0, dout0, dle0, busy0}, 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    model_reset();
    chk("no_partial_latch", 32'(capq.size()), 32'd2);
    go(1'b0);
    wait_done(1700);
    finish_check("after_reset", 1'b0, 1615, 4, 4);

    // Shadow bypass: write in R0's LOAD cycle is taken, one cycle later is not.
    do_reset();
    wr(3'd0, 32'hA5A5A5A7, 1'b1);
    go(1'b1);
    wr(3'd0, 32'h0F0F0F0D, 1'b1);
    wait_done(320);
    finish_check("bypass_load", 1'b1, 270, 4, 4);
    go(1'b1);
    step_to(2);
    wr(3'd0, 32'h7777777F, 1'b0);
    wait_done(320);
    finish_check("write_after_load", 1'b1, 270, 4, 4);
    msh[0] = 32'h7777777F;
    go(1'b1);
    wait_done(320);
    finish_check("next_quick", 1'b1, 270, 4, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
